mem_access_stage: RTL and testbench

//  Memory stage of the 5-stage RV32 pipeline, fed by the EX->MEM control/data register.

---
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 tb/tb_mem_access_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage of the RV32 pipeline: valid/ready data-memory requests, byte lanes,
// load formatting, pipeline stall generation and the MEM->WB register.
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rf_enM,
    input  logic            mem_readM,
    input  logic            mem_writeM,
    input  logic [1:0]      wb_selM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      rdM,
    input  logic [XLEN-1:0] alu_resultM,
    input  logic [XLEN-1:0] store_dataM,
    input  logic [XLEN-1:0] pc4M,
    output logic            dmem_valid,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_mem,
    output logic            rf_enW,
    output logic [1:0]      wb_selW,
    output logic [4:0]      rdW,
    output logic [XLEN-1:0] alu_resultW,
    output logic [XLEN-1:0] load_dataW,
    output logic [XLEN-1:0] pc4W,
    output logic            misalign_errW
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t r_state;

    logic [1:0]      w_off;
    logic            w_mem_op;
    logic            w_illegal;
    logic            w_err;
    logic            w_go;
    logic            w_valid;
    logic            w_stall;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_fmt;

    assign w_off = alu_resultM[1:0];

    always_comb begin
        w_mem_op  = mem_readM | mem_writeM;
        w_illegal = (mem_readM & mem_writeM)
                  | (funct3M == 3'b011)
                  | (funct3M[2:1] == 2'b11)
                  | ((funct3M[1:0] == 2'b01) & w_off[0])
                  | ((funct3M[1:0] == 2'b10) & (w_off != 2'b00));
        w_err     = w_mem_op & w_illegal;
        w_go      = w_mem_op & ~w_illegal;
    end

    // A store accepted in the same cycle it is offered never stalls.
    always_comb begin
        w_valid = 1'b0;
        w_stall = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    w_valid = w_go;
                    w_stall = w_go & ~(dmem_ready & mem_writeM);
                end
                S_REQ: begin
                    w_valid = 1'b1;
                    w_stall = ~(dmem_ready & mem_writeM);
                end
                S_WAIT: w_stall = ~dmem_rvalid;
                default: ;
            endcase
        end
    end

    assign dmem_valid = w_valid;
    assign stall_mem  = w_stall;
    assign dmem_we    = mem_writeM;
    assign dmem_addr  = {alu_resultM[XLEN-1:2], 2'b00};

    always_comb begin
        case (funct3M[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << w_off;
                dmem_wdata = {4{store_dataM[7:0]}};
            end
            2'b01: begin
                dmem_be    = w_off[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_dataM[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_dataM;
            end
        endcase
    end

    always_comb begin
        w_byte = dmem_rdata[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  w_load_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_fmt = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            rf_enW        <= '0;
            wb_selW       <= '0;
            rdW           <= '0;
            alu_resultW   <= '0;
            load_dataW    <= '0;
            pc4W          <= '0;
            misalign_errW <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) r_state <= !dmem_ready ? S_REQ : (mem_writeM ? S_IDLE : S_WAIT);
                S_REQ:  if (dmem_ready) r_state <= mem_writeM ? S_IDLE : S_WAIT;
                S_WAIT: if (dmem_rvalid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_stall) begin
                rf_enW        <= 1'b0;
                misalign_errW <= 1'b0;
            end else begin
                rf_enW        <= rf_enM & ~w_err;
                wb_selW       <= wb_selM;
                rdW           <= rdM;
                alu_resultW   <= alu_resultM;
                pc4W          <= pc4M;
                misalign_errW <= w_err;
                // Only a completing load carries response data into W.
                load_dataW    <= (r_state == S_WAIT) ? w_load_fmt : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage with a bench-side memory
// responder and an arithmetic reference model of the access rules.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        rf_enM, mem_readM, mem_writeM;
    logic [1:0]  wb_selM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] alu_resultM, store_dataM, pc4M;
    logic        dmem_valid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_mem, rf_enW;
    logic [1:0]  wb_selW;
    logic [4:0]  rdW;
    logic [31:0] alu_resultW, load_dataW, pc4W;
    logic        misalign_errW;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .rf_enM(rf_enM), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
        .wb_selM(wb_selM), .funct3M(funct3M), .rdM(rdM),
        .alu_resultM(alu_resultM), .store_dataM(store_dataM), .pc4M(pc4M),
        .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .rf_enW(rf_enW), .wb_selW(wb_selW), .rdW(rdW),
        .alu_resultW(alu_resultW), .load_dataW(load_dataW), .pc4W(pc4W),
        .misalign_errW(misalign_errW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction through M: memory accepts after rdly cycles of ready=0 and
    // answers a load vdly (>=1) cycles after acceptance.
    task automatic run_op(input string name, input logic i_rfen, i_rd, i_wr,
                          input logic [1:0] i_ws, input logic [2:0] i_f3, input logic [4:0] i_rdst,
                          input logic [31:0] i_addr, i_sd, i_pc4, i_rdata,
                          input int rdly, vdly);
        int          sz, off, total;
        logic        bad, err, go, e_valid, e_stall;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_ld, sh;

        off = int'(i_addr[1:0]);
        sz  = (i_f3[1:0] == 2'd0) ? 1 : (i_f3[1:0] == 2'd1) ? 2 : 4;
        bad = (i_rd && i_wr) || i_f3 == 3'd3 || i_f3 == 3'd6 || i_f3 == 3'd7 || (i_addr % sz != 0);
        err = (i_rd || i_wr) && bad;
        go  = (i_rd || i_wr) && !bad;
        e_be = 4'(((1 << sz) - 1) << off);
        e_wdata = (sz == 1) ? {24'b0, i_sd[7:0]} * 32'h0101_0101 :
                  (sz == 2) ? {16'b0, i_sd[15:0]} * 32'h0001_0001 : i_sd;
        sh = i_rdata >> (8 * off);
        if (sz == 1) begin
            e_ld = sh & 32'hFF;
            if (!i_f3[2] && e_ld[7]) e_ld = e_ld - 32'h100;
        end else if (sz == 2) begin
            e_ld = sh & 32'hFFFF;
            if (!i_f3[2] && e_ld[15]) e_ld = e_ld - 32'h1_0000;
        end else begin
            e_ld = i_rdata;
        end
        total = !go ? 0 : (i_wr ? rdly : rdly + vdly);

        @(negedge clk);
        rf_enM = i_rfen; mem_readM = i_rd; mem_writeM = i_wr; wb_selM = i_ws;
        funct3M = i_f3; rdM = i_rdst; alu_resultM = i_addr; store_dataM = i_sd; pc4M = i_pc4;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ready  = go ? (c == rdly) : 1'($urandom_range(1));
            if (go && i_rd && c == rdly + vdly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = i_rdata;
            end else begin
                dmem_rvalid = (!go || c < rdly) ? 1'($urandom_range(1)) : 1'b0;
                dmem_rdata  = $urandom;
            end
            #1;
            e_valid = go && c <= rdly;
            e_stall = go && c < total;
            checks++;
            if (dmem_valid !== e_valid) begin
                errors++;
                $display("FAIL %s dmem_valid cyc %0d: got %b want %b", name, c, dmem_valid, e_valid);
            end
            checks++;
            if (stall_mem !== e_stall) begin
                errors++;
                $display("FAIL %s stall_mem cyc %0d: got %b want %b", name, c, stall_mem, e_stall);
            end
            if (e_valid) begin
                checks++;
                if (dmem_addr !== {i_addr[31:2], 2'b00} || dmem_we !== i_wr ||
                    dmem_be !== e_be || (i_wr && dmem_wdata !== e_wdata)) begin
                    errors++;
                    $display("FAIL %s bus cyc %0d: got addr=%h we=%b be=%b wdata=%h want addr=%h we=%b be=%b wdata=%h",
                             name, c, dmem_addr, dmem_we, dmem_be, dmem_wdata,
                             {i_addr[31:2], 2'b00}, i_wr, e_be, e_wdata);
                end
            end
            @(posedge clk); #1;
            if (c < total) begin
                checks++;
                if (rf_enW !== 1'b0 || misalign_errW !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bubble cyc %0d: got rf_en=%b err=%b want 0 0", name, c, rf_enW, misalign_errW);
                end
            end
        end
        checks++;
        if (rf_enW !== (i_rfen && !err) || misalign_errW !== err || rdW !== i_rdst ||
            wb_selW !== i_ws || alu_resultW !== i_addr || pc4W !== i_pc4 ||
            load_dataW !== ((go && i_rd) ? e_ld : 32'h0)) begin
            errors++;
            $display("FAIL %s W: got rf=%b err=%b rd=%0d ws=%0d alu=%h pc4=%h ld=%h want rf=%b err=%b rd=%0d ws=%0d alu=%h pc4=%h ld=%h",
                     name, rf_enW, misalign_errW, rdW, wb_selW, alu_resultW, pc4W, load_dataW,
                     i_rfen && !err, err, i_rdst, i_ws, i_addr, i_pc4, (go && i_rd) ? e_ld : 32'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rf_enM = 1'b1; mem_readM = 1'b1; mem_writeM = 1'b0; wb_selM = 2'b01; funct3M = 3'b010;
        rdM = 5'd3; alu_resultM = 32'h40; store_dataM = 32'h0; pc4M = 32'h8;
        dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (dmem_valid !== 1'b0 || stall_mem !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs: got valid=%b stall=%b want 0 0", dmem_valid, stall_mem);
            end
            @(posedge clk); #1;
            checks++;
            if (rf_enW !== 1'b0 || wb_selW !== 2'b0 || rdW !== 5'd0 || alu_resultW !== 32'h0 ||
                load_dataW !== 32'h0 || pc4W !== 32'h0 || misalign_errW !== 1'b0) begin
                errors++;
                $display("FAIL reset_W: got rf=%b ws=%0d rd=%0d alu=%h ld=%h pc4=%h err=%b want all 0",
                         rf_enW, wb_selW, rdW, alu_resultW, load_dataW, pc4W, misalign_errW);
            end
        end
        @(negedge clk);
        rst = 1'b1; mem_readM = 1'b0; rf_enM = 1'b0;
    endtask

    task automatic test_directed();
        run_op("lb_0x103", 1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 5'd7, 32'h103, 32'h0, 32'h44, 32'h8011_2233, 0, 1);
        checks++;
        if (load_dataW !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_value: got %h want FFFFFF80", load_dataW);
        end
        run_op("sh_0x102", 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h102, 32'h0000_ABCD, 32'h48, 32'h0, 0, 1);
        run_op("lw_0x200", 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h200, 32'h0, 32'h4C, 32'hCAFE_F00D, 3, 2);
        checks++;
        if (load_dataW !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL lw_value: got %h want CAFEF00D", load_dataW);
        end
        run_op("lw_0x101", 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h101, 32'h0, 32'h50, 32'h0, 0, 1);
        run_op("alu_rd5", 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h54, 32'h0, 0, 1);
        checks++;
        if (rdW !== 5'd5 || alu_resultW !== 32'h1234 || rf_enW !== 1'b1) begin
            errors++;
            $display("FAIL alu_value: got rd=%0d alu=%h rf=%b want 5 1234 1", rdW, alu_resultW, rf_enW);
        end
        run_op("rw_both", 1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd4, 32'h300, 32'h1, 32'h58, 32'h0, 0, 1);
        run_op("f3_110", 1'b1, 1'b1, 1'b0, 2'b01, 3'b110, 5'd4, 32'h300, 32'h1, 32'h5C, 32'h0, 0, 1);
        run_op("lhu_0x106", 1'b1, 1'b1, 1'b0, 2'b01, 3'b101, 5'd6, 32'h106, 32'h0, 32'h60, 32'h8123_4567, 1, 3);
        run_op("sb_0x203", 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h203, 32'h0000_00A5, 32'h64, 32'h0, 2, 1);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        rf_enM = 1'b1; mem_readM = 1'b1; mem_writeM = 1'b0; wb_selM = 2'b01; funct3M = 3'b010;
        rdM = 5'd12; alu_resultM = 32'h80; pc4M = 32'h70;
        dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem_ready = 1'b0; rst = 1'b0;
        #1;
        checks++;
        if (stall_mem !== 1'b0 || dmem_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_outs: got stall=%b valid=%b want 0 0", stall_mem, dmem_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        rf_enM = 1'b0; mem_readM = 1'b0; wb_selM = 2'b00; funct3M = 3'b000; rdM = 5'd0;
        alu_resultM = 32'h0; pc4M = 32'h0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (stall_mem !== 1'b0 || dmem_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_resp: got stall=%b valid=%b want 0 0", stall_mem, dmem_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_enW !== 1'b0 || rdW !== 5'd0 || load_dataW !== 32'h0 || alu_resultW !== 32'h0 ||
            pc4W !== 32'h0 || misalign_errW !== 1'b0 || wb_selW !== 2'b0) begin
            errors++;
            $display("FAIL rstwait_W: got rf=%b rd=%0d ld=%h alu=%h pc4=%h err=%b ws=%0d want all 0",
                     rf_enW, rdW, load_dataW, alu_resultW, pc4W, misalign_errW, wb_selW);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        rd, wr;
        logic [31:0] addr;
        int          kind, sz;
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(5));
            rd = 1'b0; wr = 1'b0;
            f3 = 3'($urandom_range(7));
            addr = $urandom;
            case (kind)
                1, 2: begin
                    rd = 1'b1;
                    case ($urandom_range(4))
                        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
                    endcase
                end
                3, 4: begin
                    wr = 1'b1;
                    f3 = 3'($urandom_range(2));
                end
                5: begin
                    rd = 1'($urandom_range(1));
                    wr = 1'($urandom_range(1));
                end
                default: ;
            endcase
            if (kind >= 1 && kind <= 4 && $urandom_range(4) != 0) begin
                sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
                addr = addr - (addr % sz);
            end
            run_op("random", 1'($urandom_range(1)), rd, wr, 2'($urandom_range(2)), f3,
                   5'($urandom), addr, $urandom, $urandom, $urandom,
                   int'($urandom_range(3)), int'($urandom_range(3, 1)));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_op("b2b_sw", 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h400 + 32'(4 * n), $urandom, 32'h100, 32'h0, 0, 1);
            run_op("b2b_lw", 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'(n + 1), 32'h400 + 32'(4 * n), 32'h0, 32'h104, $urandom, 0, 1);
        end
    endtask

    initial begin
        rst = 1'b0;
        rf_enM = 1'b0; mem_readM = 1'b0; mem_writeM = 1'b0; wb_selM = 2'b0; funct3M = 3'b0;
        rdM = 5'd0; alu_resultM = 32'h0; store_dataM = 32'h0; pc4M = 32'h0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        test_reset();
        test_directed();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
